// File: rtl/gray_to_bin_sync_if.sv
// Gray-code crossing bus: upstream Gray value in, resynchronised binary view out.
interface gray_to_bin_sync_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             bin_change;
  logic             step_err;

  // No backpressure: bin_out is meaningful whenever bin_valid=1, and
  // bin_change/step_err are only ever raised while bin_valid=1.
  modport master (
    output gray_in,
    input  bin_out, bin_valid, bin_change, step_err
  );

  modport slave (
    input  gray_in,
    output bin_out, bin_valid, bin_change, step_err
  );
endinterface

// File: rtl/gray_to_bin_sync.sv
// Resynchronises a Gray-coded value, converts it to binary and flags changes and multi-bit steps.
// Optional macro GRAY_SYNC_STICKY_ERR_EN makes step_err hold until reset.
module gray_to_bin_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  gray_to_bin_sync_if.slave  bus
);
  localparam int CW = $clog2(SYNC_STAGES + 2);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s_last;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] diff_m1;
  logic [CW-1:0]    warm_cnt;
  logic             valid_q;
  logic             change_q;
  logic             err_q;
  logic             changed;
  logic             multi_bit;

  assign s_last = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_next[i] = ^(s_last >> i);
    end
  end

  // More than one set bit: clearing the lowest set bit leaves something.
  always_comb begin
    diff      = s_last ^ gray_q;
    diff_m1   = diff - WIDTH'(1);
    changed   = (diff != '0);
    multi_bit = ((diff & diff_m1) != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= bus.gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // valid_q rises on the (SYNC_STAGES+1)th edge after release; counter saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      warm_cnt <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (warm_cnt != CW'(SYNC_STAGES)) begin
        warm_cnt <= warm_cnt + 1'b1;
      end
      valid_q <= valid_q | (warm_cnt == CW'(SYNC_STAGES));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gray_q   <= '0;
      bin_q    <= '0;
      change_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      gray_q   <= s_last;
      bin_q    <= bin_next;
      change_q <= valid_q & changed;
`ifdef GRAY_SYNC_STICKY_ERR_EN
      err_q    <= err_q | (valid_q & multi_bit);
`else
      err_q    <= valid_q & multi_bit;
`endif
    end
  end

  assign bus.bin_out    = bin_q;
  assign bus.bin_valid  = valid_q;
  assign bus.bin_change = change_q;
  assign bus.step_err   = err_q;
endmodule

// File: tb/tb_gray_to_bin_sync.sv
// Directed bench for gray_to_bin_sync: reset/warm-up, full sweep, wrap, illegal jump, mid-run reset.
module tb_gray_to_bin_sync;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   n_fail;
  int   pulses;
  int   errs;
  int   exp_pulses;
  logic [3:0] exp_q[$];
  logic [3:0] exp_v;
  logic       exp_err_after;

  gray_to_bin_sync_if #(.WIDTH(4)) bus ();

  gray_to_bin_sync #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] g);
    bus.gray_in = g;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
`ifdef GRAY_SYNC_STICKY_ERR_EN
    exp_err_after = 1'b1;
`else
    exp_err_after = 1'b0;
`endif

    // Reset + warm-up with gray 1010 (bin 1100)
    rst_n = 1'b0;
    drive(4'b1010);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_outputs", 16'({bus.bin_out, bus.bin_valid, bus.bin_change, bus.step_err}), 16'h0);
    end
    rst_n = 1'b1;
    tick();
    tick();
    check("warm_valid_low", 16'(bus.bin_valid), 16'h0);
    tick();
    check("warm_valid_high", 16'(bus.bin_valid), 16'h1);
    check("warm_bin", 16'(bus.bin_out), 16'hc);
    check("warm_change", 16'(bus.bin_change), 16'h0);
    check("warm_err", 16'(bus.step_err), 16'h0);
    tick();
    check("warm_change_next", 16'(bus.bin_change), 16'h0);

    // Re-reset onto code 0 so the sweep starts without a multi-bit step
    rst_n = 1'b0;
    drive(4'b0000);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("sweep_start_valid", 16'(bus.bin_valid), 16'h1);

    // Full sweep 0..15, each held 4 cycles
    for (int b = 0; b < 16; b++) begin
      drive(to_gray(b));
      exp_q.push_back(4'(b));
      exp_pulses = (b == 0) ? 0 : 1;
      pulses = 0;
      errs   = 0;
      for (int t = 1; t <= 4; t++) begin
        tick();
        pulses += int'(bus.bin_change);
        errs   += int'(bus.step_err);
        if (t == 3) begin
          exp_v = exp_q.pop_front();
          check($sformatf("sweep_bin_%0d", b), 16'(bus.bin_out), 16'(exp_v));
        end
      end
      check($sformatf("sweep_pulses_%0d", b), 16'(pulses), 16'(exp_pulses));
      check($sformatf("sweep_err_%0d", b), 16'(errs), 16'h0);
    end

    // Wrap 1000 (bin 15) -> 0000
    drive(4'b0000);
    tick();
    tick();
    check("wrap_before", 16'(bus.bin_out), 16'hf);
    tick();
    check("wrap_bin", 16'(bus.bin_out), 16'h0);
    check("wrap_change", 16'(bus.bin_change), 16'h1);
    check("wrap_err", 16'(bus.step_err), 16'h0);
    tick();
    check("wrap_change_next", 16'(bus.bin_change), 16'h0);

    // Illegal two-bit jump 0000 -> 0011
    drive(4'b0011);
    tick();
    tick();
    check("jump_err_early", 16'(bus.step_err), 16'h0);
    tick();
    check("jump_bin", 16'(bus.bin_out), 16'h2);
    check("jump_change", 16'(bus.bin_change), 16'h1);
    check("jump_err", 16'(bus.step_err), 16'h1);
    tick();
    check("jump_change_next", 16'(bus.bin_change), 16'h0);
    check("jump_err_next", 16'(bus.step_err), 16'(exp_err_after));

    // Walk legally up to bin 9
    for (int b = 3; b <= 9; b++) begin
      drive(to_gray(b));
      for (int t = 0; t < 4; t++) tick();
    end
    check("walk_bin9", 16'(bus.bin_out), 16'h9);
    check("walk_err", 16'(bus.step_err), 16'(exp_err_after));

    // Mid-run reset for one edge
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_bin", 16'(bus.bin_out), 16'h0);
    check("mid_rst_valid", 16'(bus.bin_valid), 16'h0);
    check("mid_rst_err", 16'(bus.step_err), 16'h0);
    tick();
    tick();
    check("mid_warm_valid_low", 16'(bus.bin_valid), 16'h0);
    tick();
    check("mid_warm_valid", 16'(bus.bin_valid), 16'h1);
    check("mid_warm_bin", 16'(bus.bin_out), 16'h9);
    check("mid_warm_change", 16'(bus.bin_change), 16'h0);
    tick();
    check("mid_static_change", 16'(bus.bin_change), 16'h0);
    check("mid_static_err", 16'(bus.step_err), 16'h0);

    // Final report
    check("scoreboard_empty", 16'(exp_q.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
